// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_pkg                                                  |
// | Purpose  : Shared types and constants for the data-memory responder: |
// |            FSM state encoding, word geometry, wait-counter width and |
// |            the read data returned on an error completion.            |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   // Bytes per array word; the low log2 address bits select a byte.
   localparam int WORD_BYTES = 4;

   // Wait-state counter width; WAIT_CYC must fit (0..15).
   localparam int CNT_W = 4;

   // Read data returned by any access that completes with err=1.
   localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_responder_if                                         |
// | Purpose  : Request/response bundle between the datapath memory port  |
// |            and the data-memory responder.                            |
// | Ports    : req, rw, addr, wdata  (requester -> responder)            |
// |            rdata, ack, busy, err (responder -> requester)            |
// |            modport master = requester side, slave = responder side   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface dmem_responder_if;

   logic        req;
   logic        rw;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;
   logic        busy;
   logic        err;

   modport master (
      output req, rw, addr, wdata,
      input  rdata, ack, busy, err
   );

   modport slave (
      input  req, rw, addr, wdata,
      output rdata, ack, busy, err
   );

endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_array                                                |
// | Purpose  : Single-port 32-bit word storage. Synchronous write,       |
// |            registered read, no reset (contents survive reset).      |
// | Ports    : clk      clock, rising edge                               |
// |            i_we     write enable                                     |
// |            i_re     read enable (updates o_q on the edge)            |
// |            i_idx    word index                                       |
// |            i_wdata  write data                                       |
// |            o_q      registered read data                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dmem_array #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  wire logic             clk,
   input  wire logic             i_we,
   input  wire logic             i_re,
   input  wire logic [IDX_W-1:0] i_idx,
   input  wire logic [31:0]      i_wdata,
   output logic      [31:0]      o_q
);

   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_q;

   // Read-before-write on a shared index: o_q returns the old word.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_idx] <= i_wdata;
      end
      if (i_re) begin
         r_q <= r_mem[i_idx];
      end
   end

   assign o_q = r_q;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmem_responder                                            |
// | Purpose  : Data-memory responder for the datapath memory port.       |
// |            Accepts a word request, counts WAIT_CYC wait states,      |
// |            performs the access, then pulses ack for one cycle with   |
// |            err flagging out-of-range (and optionally misaligned)     |
// |            accesses.                                                 |
// | Ports    : clk    clock, rising edge                                 |
// |            reset  asynchronous, active-low reset                     |
// |            bus    dmem_responder_if.slave (req/rw/addr/wdata in,     |
// |                   rdata/ack/busy/err out)                            |
// | Config   : `define DMEM_MISALIGN_TRAP_EN to treat addr[1:0]!=0 as an |
// |            error; otherwise the low bits are ignored.                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int WAIT_CYC = 2
) (
   input wire logic        clk,
   input wire logic        reset,
   dmem_responder_if.slave bus
);

   localparam int c_off_w = $clog2(WORD_BYTES);
   localparam int c_idx_w = ADDR_W - c_off_w;
   localparam int c_depth = 1 << c_idx_w;
   localparam logic [CNT_W-1:0] c_wait_load = CNT_W'(WAIT_CYC);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic               r_rw;
   logic [31:0]        r_rdata;
   logic               r_ack;
   logic               r_busy;
   logic               r_err;

   logic               w_oor;
   logic               w_misalign;
   logic               w_bad;
   logic               w_access;
   logic               w_we;
   logic               w_re;
   logic [c_idx_w-1:0] w_idx;
   logic [31:0]        w_q;

   assign w_oor = (r_addr >> ADDR_W) != 32'h0;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_misalign = (r_addr[c_off_w-1:0] != '0);
`else
   logic w_unused_lsb;
   assign w_misalign   = 1'b0;
   assign w_unused_lsb = ^r_addr[c_off_w-1:0];
`endif

   assign w_bad    = w_oor | w_misalign;
   assign w_access = (r_state == WAIT) && (r_cnt == '0);
   assign w_we     = w_access && r_rw && !w_bad;

   // The array read is registered, so it is issued one edge ahead of the
   // access. In IDLE the live bus address is used so that with WAIT_CYC=0
   // the word is already in o_q at the access edge; afterwards the latched
   // address keeps the read fresh for every WAIT cycle.
   assign w_re  = (r_state != RESP);
   assign w_idx = (r_state == IDLE) ? bus.addr[ADDR_W-1:c_off_w]
                                    : r_addr[ADDR_W-1:c_off_w];

   dmem_array #(
      .DEPTH (c_depth),
      .IDX_W (c_idx_w)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_idx   (w_idx),
      .i_wdata (r_wdata),
      .o_q     (w_q)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rw    <= 1'b0;
         r_rdata <= 32'h0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_ack <= 1'b0;
               r_err <= 1'b0;
               if (bus.req) begin
                  r_addr  <= bus.addr;
                  r_rw    <= bus.rw;
                  r_wdata <= bus.wdata;
                  r_cnt   <= c_wait_load;
                  r_busy  <= 1'b1;
                  r_state <= WAIT;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  // Access edge: the array write happens via w_we.
                  r_ack   <= 1'b1;
                  r_err   <= w_bad;
                  r_state <= RESP;
                  if (!r_rw) begin
                     r_rdata <= w_bad ? ERR_RDATA : w_q;
                  end
               end
            end
            RESP: begin
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_ack   <= 1'b0;
               r_err   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.rdata = r_rdata;
   assign bus.ack   = r_ack;
   assign bus.busy  = r_busy;
   assign bus.err   = r_err;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                         |
// | Purpose  : Directed self-checking bench for dmem_responder. Three    |
// |            instances cover WAIT_CYC = 2, 0 and 3; one request bus    |
// |            is steered to the selected instance.                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, rst_c;
   int          sel;
   logic        t_req, t_rw;
   logic [31:0] t_addr, t_wdata;
   logic [31:0] m_rdata;
   logic        m_ack, m_busy, m_err;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   dmem_responder_if bus_a ();
   dmem_responder_if bus_b ();
   dmem_responder_if bus_c ();

   dmem_responder #(.ADDR_W(12), .WAIT_CYC(2)) u_a (.clk(clk), .reset(rst_a), .bus(bus_a.slave));
   dmem_responder #(.ADDR_W(12), .WAIT_CYC(0)) u_b (.clk(clk), .reset(rst_b), .bus(bus_b.slave));
   dmem_responder #(.ADDR_W(12), .WAIT_CYC(3)) u_c (.clk(clk), .reset(rst_c), .bus(bus_c.slave));

   assign bus_a.req = t_req && (sel == 0);
   assign bus_b.req = t_req && (sel == 1);
   assign bus_c.req = t_req && (sel == 2);
   assign bus_a.rw = t_rw;   assign bus_a.addr = t_addr;   assign bus_a.wdata = t_wdata;
   assign bus_b.rw = t_rw;   assign bus_b.addr = t_addr;   assign bus_b.wdata = t_wdata;
   assign bus_c.rw = t_rw;   assign bus_c.addr = t_addr;   assign bus_c.wdata = t_wdata;

   always_comb begin
      m_rdata = bus_a.rdata; m_ack = bus_a.ack; m_busy = bus_a.busy; m_err = bus_a.err;
      if (sel == 1) begin
         m_rdata = bus_b.rdata; m_ack = bus_b.ack; m_busy = bus_b.busy; m_err = bus_b.err;
      end else if (sel == 2) begin
         m_rdata = bus_c.rdata; m_ack = bus_c.ack; m_busy = bus_c.busy; m_err = bus_c.err;
      end
   end

   // One transaction: req high for the acceptance edge only, then wait
   // (bounded) for ack. lat counts cycles from acceptance to the ack sample;
   // a timeout returns lat=40, which no latency expectation matches.
   task automatic do_txn(input int s, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd,
                         output logic e, output int lat,
                         output logic ack_nx, output logic err_nx);
      sel = s; t_rw = w; t_addr = a; t_wdata = d; t_req = 1'b1;
      @(posedge clk); #1;
      t_req = 1'b0;
      lat = 0;
      while (m_ack !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = m_rdata; e = m_err;
      @(posedge clk); #1;
      ack_nx = m_ack; err_nx = m_err;
   endtask

   task automatic test_reset();
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      t_req = 1'b0; t_rw = 1'b0; t_addr = '0; t_wdata = '0; sel = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      for (int s = 0; s < 3; s++) begin
         sel = s; #0;
         total++;
         if ({m_ack, m_busy, m_err} !== 3'b000 || m_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state[%0d]: ack/busy/err=%b%b%b rdata=%h, expected 000 and 0", s, m_ack, m_busy, m_err, m_rdata);
         end
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         for (int s = 0; s < 3; s++) begin
            sel = s; #0;
            total++;
            if (m_ack !== 1'b0 || m_busy !== 1'b0) begin
               bad++;
               $display("FAIL idle_quiet[%0d]: ack=%b busy=%b, expected 0 0", s, m_ack, m_busy);
            end
         end
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd; logic e, an, en; int lat;
      do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat, an, en);
      total++;
      if (lat !== 3 || e !== 1'b0) begin
         bad++;
         $display("FAIL wr_latency: lat=%0d err=%b, expected 3 0", lat, e);
      end
      total++;
      if (an !== 1'b0 || en !== 1'b0) begin
         bad++;
         $display("FAIL ack_one_cycle: ack=%b err=%b after ack, expected 0 0", an, en);
      end
      do_txn(0, 1'b0, 32'h10, 32'h0, rd, e, lat, an, en);
      total++;
      if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL rd_10: lat=%0d err=%b rdata=%h, expected 3 0 deadbeef", lat, e, rd);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] rd; logic e, an, en; int lat;
      do_txn(0, 1'b1, 32'h0, 32'h12345678, rd, e, lat, an, en);
      total++;
      if (lat !== 3 || e !== 1'b0) begin
         bad++;
         $display("FAIL wr_word0: lat=%0d err=%b, expected 3 0", lat, e);
      end
      // 0x1000 aliases word 0 in the index bits; the write must be dropped.
      do_txn(0, 1'b1, 32'h1000, 32'h1, rd, e, lat, an, en);
      total++;
      if (lat !== 3 || e !== 1'b1 || en !== 1'b0) begin
         bad++;
         $display("FAIL oor_write: lat=%0d err=%b err_after=%b, expected 3 1 0", lat, e, en);
      end
      total++;
      if (rd !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL rdata_hold_on_write: rdata=%h, expected deadbeef", rd);
      end
      do_txn(0, 1'b0, 32'h0, 32'h0, rd, e, lat, an, en);
      total++;
      if (e !== 1'b0 || rd !== 32'h12345678) begin
         bad++;
         $display("FAIL word0_intact: err=%b rdata=%h, expected 0 12345678", e, rd);
      end
      do_txn(0, 1'b0, 32'h1000, 32'h0, rd, e, lat, an, en);
      total++;
      if (lat !== 3 || e !== 1'b1 || rd !== 32'h0) begin
         bad++;
         $display("FAIL oor_read: lat=%0d err=%b rdata=%h, expected 3 1 0", lat, e, rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic e, an, en; int lat, gap;
      do_txn(1, 1'b1, 32'h0, 32'hA, rd, e, lat, an, en);
      total++;
      if (lat !== 1) begin
         bad++;
         $display("FAIL w0_latency: lat=%0d, expected 1", lat);
      end
      do_txn(1, 1'b1, 32'h4, 32'hB, rd, e, lat, an, en);
      sel = 1; t_rw = 1'b0; t_addr = 32'h0; t_req = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (m_ack !== 1'b1 && lat < 40);
      total++;
      if (lat !== 2 || m_rdata !== 32'hA || m_err !== 1'b0) begin
         bad++;
         $display("FAIL b2b_first: lat=%0d rdata=%h err=%b, expected 2 0000000a 0", lat, m_rdata, m_err);
      end
      t_addr = 32'h4;   // req stays high
      gap = 0;
      do begin
         @(posedge clk); #1;
         if (m_ack !== 1'b1) gap++;
      end while (m_ack !== 1'b1 && gap < 40);
      t_req = 1'b0;
      total++;
      if (gap !== 2 || m_rdata !== 32'hB) begin
         bad++;
         $display("FAIL b2b_second: ack_low_cycles=%0d rdata=%h, expected 2 0000000b", gap, m_rdata);
      end
      gap = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (m_ack === 1'b1) gap++;
      end
      total++;
      if (gap !== 0) begin
         bad++;
         $display("FAIL b2b_no_repeat: extra_acks=%0d, expected 0", gap);
      end
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] rd; logic e, an, en; int lat, acks;
      do_txn(2, 1'b1, 32'h20, 32'h11, rd, e, lat, an, en);
      total++;
      if (lat !== 4) begin
         bad++;
         $display("FAIL w3_latency: lat=%0d, expected 4", lat);
      end
      sel = 2; t_rw = 1'b1; t_addr = 32'h20; t_wdata = 32'h55; t_req = 1'b1;
      @(posedge clk); #1;              // accepted
      t_req = 1'b0;
      @(posedge clk); #1;              // second WAIT cycle
      total++;
      if (m_busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_busy: busy=%b, expected 1", m_busy);
      end
      rst_c = 1'b0;
      #1;
      total++;
      if (m_busy !== 1'b0 || m_ack !== 1'b0) begin
         bad++;
         $display("FAIL async_abort: busy=%b ack=%b, expected 0 0", m_busy, m_ack);
      end
      acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (m_ack === 1'b1) acks++;
      end
      rst_c = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (m_ack === 1'b1) acks++;
      end
      total++;
      if (acks !== 0) begin
         bad++;
         $display("FAIL abort_no_ack: acks=%0d, expected 0", acks);
      end
      do_txn(2, 1'b0, 32'h20, 32'h0, rd, e, lat, an, en);
      total++;
      if (lat !== 4 || e !== 1'b0 || rd !== 32'h11) begin
         bad++;
         $display("FAIL aborted_write: lat=%0d err=%b rdata=%h, expected 4 0 00000011", lat, e, rd);
      end
   endtask

   task automatic test_misalign();
      logic [31:0] rd; logic e, an, en; int lat;
      do_txn(0, 1'b0, 32'h0, 32'h0, rd, e, lat, an, en);   // rdata = 12345678
      do_txn(0, 1'b0, 32'h12, 32'h0, rd, e, lat, an, en);
`ifdef DMEM_MISALIGN_TRAP_EN
      total++;
      if (lat !== 3 || e !== 1'b1 || rd !== 32'h0) begin
         bad++;
         $display("FAIL misalign_trap: lat=%0d err=%b rdata=%h, expected 3 1 0", lat, e, rd);
      end
`else
      total++;
      if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL misalign_ignored: lat=%0d err=%b rdata=%h, expected 3 0 deadbeef", lat, e, rd);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_write();
      test_misalign();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_dmem_responder
`default_nettype wire
